knight_rider_monitor: RTL
=========================

# knight_rider_monitor

Receiving-end checker for the 16-LED knight-rider scanner bus. Samples the 16-bit LED pattern and decodes the lit position (0 = LSB, 15 = MSB) and the scan direction. Counts end-of-travel bounces and flags illegal patterns, skipped steps, illegal reversals and stalls. Sits on the LED bus beside the scanner, for on-board self-test and bench checking.

## Interface
- `WIDTH`, 16: LED bus width. The logic is fixed at 16; the parameter is for documentation and package use only.
- `STALL_LIMIT`, 26'h2000000: cycles without a pattern change before `stall` asserts. Must exceed the scanner step period.
- `clk` input, 1 bit: the single clock; all state changes on its rising edge.
- `rst` input, 1 bit: **asynchronous, active-high** reset.
- `clr` input, 1 bit: synchronous soft clear. Returns the block to IDLE, clears `error`/`errorCode`/`bounceCount`/`stall`.
- `dataIn` input, 16 bits: LED pattern under observation.
- `position` output, 4 bits: index of the lit LED.
- `posValid` output, 1 bit: `position` is meaningful.
- `dir` output, 1 bit: scan direction. 1 = toward MSB, 0 = toward LSB.
- `stepStrobe` output, 1 bit: one-cycle pulse per legal step.
- `bounceCount` output, 8 bits: legal reversals seen; saturates at 255.
- `stall` output, 1 bit: no pattern change for `STALL_LIMIT` cycles.
- `error` output, 1 bit: sticky error flag.
- `errorCode` output, 2 bits: first error seen. 0 none, 1 NOT_ONEHOT, 2 SKIP, 3 BAD_REVERSAL.

## Operation
- **Input sampling.** `dataIn` is registered into `sample`. `prev` holds the last accepted pattern. A change event means `sample != prev`.
- **IDLE.**
  - Non-one-hot `sample` (including zero) is ignored; no error.
  - One-hot `sample`: load `prev` and `position`, set `posValid`=1, go to ACQ.
- **ACQ** (position known, direction unknown). On a change event:
  - Not one-hot -> ERROR, code 1.
  - Step of 1 in either direction -> set `dir` (no reversal check), pulse `stepStrobe`, go to TRACK.
  - Any other jump -> ERROR, code 2.
- **TRACK.** On a change event:
  - Not one-hot -> code 1.
  - |new − old| ≠ 1 -> code 2.
  - Same direction as `dir` -> legal step.
  - Opposite direction -> legal only if old position is 0 (reversing toward MSB) or 15 (reversing toward LSB). Otherwise code 3.
  - A legal reversal toggles `dir` and increments `bounceCount` (saturating).
  - Every legal step pulses `stepStrobe` and updates `prev`/`position`.
- **ERROR.**
  - `error`=1, `posValid`=0, `stepStrobe`=0.
  - `position`, `dir`, `bounceCount` frozen.
  - `errorCode` holds the first error; later errors do not overwrite it.
  - Exit only via `clr` or `rst`.
- **Stall.**
  - The counter runs in ACQ/TRACK and clears on any accepted change.
  - On reaching `STALL_LIMIT`, `stall`=1 and the counter saturates.
  - `stall` clears on the next legal step, `clr`, or `rst`.
  - `stall` is not an error.
  - The counter is frozen and `stall` is held 0 in IDLE/ERROR.
- **Priority.** `rst` > `clr` > change-event handling. A change coincident with `clr` is discarded; IDLE reacquires from `sample` on the following cycle.

## Timing
- **Reset values.**
  - `position`=0, `posValid`=0, `dir`=0, `stepStrobe`=0, `bounceCount`=0, `stall`=0, `error`=0, `errorCode`=0.
  - State is IDLE; `sample` and `prev` are 0; the stall counter is 0.
- **Latency.** A `dataIn` change at edge k is in `sample` after edge k. Outputs reflect it after edge k+1, i.e. 2 cycles from input to output.
- `stepStrobe` is high for exactly the one cycle following the updating edge.
- Consecutive changes on consecutive cycles are each processed; there is no back-pressure.
- `rst` asserted mid-scan clears all state immediately, without waiting for a clock edge.
- `stall` asserts on the edge at which the counter equals `STALL_LIMIT`.

## Structure
- **Package `kr_pkg`:**
  - state enum: IDLE, ACQ, TRACK, ERROR;
  - error code constants: NONE, NOT_ONEHOT, SKIP, BAD_REVERSAL;
  - `WIDTH` = 16.
- **Sub-module `onehot_encoder`:** combinational, 16 -> 4-bit index plus `isOneHot`. Instantiated once on `sample`; the previous index comes from `position`.

## Test plan
- **Full scan:** reset, then drive 0x8000, 0x4000 … 0x0001, 0x0002 … 0x8000, 0x4000, one step per 8 cycles.
  - `stepStrobe` pulses on every step.
  - `dir` goes 0, then 1 after the pos-0 bounce, then 0 after the pos-15 bounce.
  - `bounceCount`=2; `error`=0.
- **Skip:** in TRACK at 0x0100 moving toward LSB, drive 0x0040.
  - After 2 cycles: `error`=1, `errorCode`=2, `posValid`=0, `position`=8 frozen.
- **Bad reversal:** at 0x0100 moving toward LSB, drive 0x0200 -> `errorCode`=3.
- **Not one-hot, then clear:** in TRACK, drive 0x0300 -> `errorCode`=1. Then a further skip leaves `errorCode` at 1. Then pulse `clr` with `dataIn`=0x0010 -> IDLE, then `posValid`=1 and `position`=4 two cycles later.
- **Stall:** with `STALL_LIMIT`=20, hold 0x0008 in TRACK -> `stall`=1 after 20 cycles. Next legal step clears `stall` and pulses `stepStrobe`.
- **Async reset mid-scan:** assert `rst` between clock edges while `bounceCount`=3 -> all outputs at reset values before the next edge. IDLE ignores `dataIn`=0x0000 with no error.

Source files
------------

// File: rtl/kr_pkg.sv
// Shared types and constants for the knight-rider LED bus monitor.
package kr_pkg;
  localparam int unsigned WIDTH   = 16;
  localparam int unsigned POS_W   = 4;
  localparam int unsigned STALL_W = 26;

  typedef enum logic [1:0] {IDLE, ACQ, TRACK, ERROR} state_t;

  typedef enum logic [1:0] {
    NONE         = 2'd0,
    NOT_ONEHOT   = 2'd1,
    SKIP         = 2'd2,
    BAD_REVERSAL = 2'd3
  } err_code_t;
endpackage

// File: rtl/onehot_encoder.sv
// Combinational 16-to-4 index encoder with a one-hot validity flag.
module onehot_encoder
  import kr_pkg::*;
(
  input  logic [WIDTH-1:0] i_data,
  output logic [POS_W-1:0] o_index,
  output logic             o_is_onehot
);

  always_comb begin
    o_index = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (i_data[i]) o_index = o_index | POS_W'(i);
    end
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
    o_is_onehot = (i_data != '0) && ((i_data & (i_data - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/knight_rider_monitor.sv
// Receiving-end checker for the 16-LED scanner bus: tracks position/direction,
// counts end-of-travel bounces and flags illegal patterns, skips, reversals and stalls.
module knight_rider_monitor #(
  parameter int unsigned WIDTH       = 16,
  parameter logic [25:0] STALL_LIMIT = 26'h2000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] dataIn,
  output logic [3:0]       position,
  output logic             posValid,
  output logic             dir,
  output logic             stepStrobe,
  output logic [7:0]       bounceCount,
  output logic             stall,
  output logic             error,
  output logic [1:0]       errorCode
);
  import kr_pkg::*;

  state_t             r_state;
  err_code_t          r_code;
  logic [15:0]        r_sample;
  logic [15:0]        r_prev;
  logic [STALL_W-1:0] r_stall_cnt;

  logic [POS_W-1:0]   w_new_pos;
  logic               w_onehot;
  logic               w_change;
  logic               w_up;
  logic               w_down;
  logic               w_reverse;
  logic               w_at_end;
  err_code_t          w_code;

  onehot_encoder u_enc (
    .i_data      (r_sample),
    .o_index     (w_new_pos),
    .o_is_onehot (w_onehot)
  );

  assign errorCode = r_code;
  assign w_change  = (r_sample != r_prev);
  // Widened compares so 15->0 and 0->15 never look like single steps.
  assign w_up      = ({1'b0, w_new_pos} == ({1'b0, position} + 5'd1));
  assign w_down    = (({1'b0, w_new_pos} + 5'd1) == {1'b0, position});
  assign w_reverse = (r_state == TRACK) && (w_up != dir);
  assign w_at_end  = (w_up && (position == 4'd0)) || (w_down && (position == 4'd15));

  always_comb begin
    w_code = NONE;
    if (!w_onehot)                 w_code = NOT_ONEHOT;
    else if (!(w_up || w_down))    w_code = SKIP;
    else if (w_reverse && !w_at_end) w_code = BAD_REVERSAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_code      <= NONE;
      r_sample    <= '0;
      r_prev      <= '0;
      r_stall_cnt <= '0;
      position    <= '0;
      posValid    <= 1'b0;
      dir         <= 1'b0;
      stepStrobe  <= 1'b0;
      bounceCount <= '0;
      stall       <= 1'b0;
      error       <= 1'b0;
    end else begin
      r_sample   <= dataIn;
      stepStrobe <= 1'b0;
      if (clr) begin
        r_state     <= IDLE;
        r_code      <= NONE;
        r_stall_cnt <= '0;
        posValid    <= 1'b0;
        bounceCount <= '0;
        stall       <= 1'b0;
        error       <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_onehot) begin
              r_prev      <= r_sample;
              position    <= w_new_pos;
              posValid    <= 1'b1;
              r_stall_cnt <= '0;
              r_state     <= ACQ;
            end
          end
          ACQ, TRACK: begin
            if (w_change) begin
              if (w_code != NONE) begin
                r_state  <= ERROR;
                r_code   <= w_code;
                error    <= 1'b1;
                posValid <= 1'b0;
                stall    <= 1'b0;
              end else begin
                if (w_reverse && (bounceCount != 8'hFF)) bounceCount <= bounceCount + 8'd1;
                dir         <= w_up;
                r_prev      <= r_sample;
                position    <= w_new_pos;
                stepStrobe  <= 1'b1;
                stall       <= 1'b0;
                r_stall_cnt <= '0;
                r_state     <= TRACK;
              end
            end else if (r_stall_cnt != STALL_LIMIT) begin
              r_stall_cnt <= r_stall_cnt + STALL_W'(1);
              if ((r_stall_cnt + STALL_W'(1)) == STALL_LIMIT) stall <= 1'b1;
            end
          end
          ERROR: begin
          end
        endcase
      end
    end
  end

endmodule
